// File: rtl/bcd_button_pkg.sv
// bcd_button_pkg: shared types, button indices and BCD digit helper for the button controller
package bcd_button_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CLR = 2;

  typedef logic [3:0] bcd_t;

  // One BCD digit step up or down with 9<->0 wrap; carry/borrow is decided by the caller
  function automatic bcd_t bcd_step(input bcd_t d, input logic up);
    return up ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// btn_debounce_fsm: synchronizer plus press/release debounce FSM for one button; auto-repeat under BCD_BUTTON_AUTOREPEAT_EN
module btn_debounce_fsm
  import bcd_button_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 32,
  parameter int REPEAT_TICKS = 8,
  parameter int REPEAT_ALLOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic tick,
  output logic evt
);

  localparam logic [3:0] ST = 4'(STABLE_TICKS);

  logic [1:0] sync;
  logic       btn_s;
  logic [3:0] stab;
  logic [3:0] stab_n;
  logic       stab_done;
  btn_state_t state;

  assign btn_s     = ~sync[1];
  assign stab_n    = stab + 4'd1;
  assign stab_done = stab_n == ST;

`ifdef BCD_BUTTON_AUTOREPEAT_EN
  localparam logic [7:0] HT = 8'(HOLD_TICKS);
  localparam logic [7:0] RT = 8'(REPEAT_TICKS);

  logic [7:0] hold;
  logic [7:0] rep;
  logic       rep_done;

  assign rep_done = rep + 8'd1 == RT;
`endif

  // Two-flop synchronizer; resets to the released level so a held button is seen fresh after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], btn_n};

  // Debounce FSM stepped on the prescaler tick; stab counts consecutive samples of the new level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stab  <= '0;
      evt   <= 1'b0;
`ifdef BCD_BUTTON_AUTOREPEAT_EN
      hold  <= '0;
      rep   <= '0;
`endif
    end else begin
      evt <= 1'b0;
      if (tick)
        case (state)
          IDLE, PRESS_WAIT: begin
            stab  <= btn_s && !stab_done ? stab_n : '0;
            state <= !btn_s ? IDLE : stab_done ? PRESSED : PRESS_WAIT;
            evt   <= btn_s && stab_done;
`ifdef BCD_BUTTON_AUTOREPEAT_EN
            if (btn_s && stab_done) begin
              hold <= '0;
              rep  <= '0;
            end
`endif
          end
          PRESSED, RELEASE_WAIT: begin
            stab  <= !btn_s && !stab_done ? stab_n : '0;
            state <= btn_s ? PRESSED : stab_done ? IDLE : RELEASE_WAIT;
`ifdef BCD_BUTTON_AUTOREPEAT_EN
            // hold saturates at HOLD_TICKS, after which rep paces the repeats; a release glitch leaves both untouched
            if (state == PRESSED && btn_s) begin
              hold <= hold == HT ? hold : hold + 8'd1;
              rep  <= hold != HT || rep_done ? '0 : rep + 8'd1;
              evt  <= REPEAT_ALLOW != 0 && (hold != HT ? hold + 8'd1 == HT : rep_done);
            end
`endif
          end
        endcase
    end

endmodule

// File: rtl/bcd_button_ctrl.sv
// bcd_button_ctrl: prescaler, three debounced buttons and a two-digit BCD up/down/clear counter; BCD_BUTTON_AUTOREPEAT_EN enables inc/dec auto-repeat
module bcd_button_ctrl
  import bcd_button_pkg::*;
#(
  parameter int PRESCALE_W   = 16,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 32,
  parameter int REPEAT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_n,
  output bcd_t       ones,
  output bcd_t       tens,
  output logic [2:0] evt,
  output logic       tick
);

  logic [PRESCALE_W-1:0] pre;

  // Free-running prescaler; tick is high in the cycle the counter sits at 0 after a wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= pre + 1'b1;
      tick <= &pre;
    end

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_ALLOW(g == BTN_CLR ? 0 : 1)
    ) u_fsm (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_n(btn_n[g]),
      .tick (tick),
      .evt  (evt[g])
    );
  end

  // BCD counter with clear > increment > decrement; tens moves only when ones wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ones <= '0;
      tens <= '0;
    end else if (evt[BTN_CLR]) begin
      ones <= '0;
      tens <= '0;
    end else if (evt[BTN_INC] || evt[BTN_DEC]) begin
      ones <= bcd_step(ones, evt[BTN_INC]);
      if (ones == (evt[BTN_INC] ? 4'd9 : 4'd0)) tens <= bcd_step(tens, evt[BTN_INC]);
    end

endmodule
